// File: rtl/alu_rs_scheduler.sv
// Integer ALU reservation station: buffers dispatched ops, wakes sources off the CDB, issues one ready op per cycle.
// Latency: dispatch to ALU 2 edges minimum, CDB wakeup to ALU 1 edge; throughput 1 op/cycle.
// Backpressure: in_ready drops only when all entries are occupied. Optional oldest-first select via ALU_RS_AGE_EN.
module alu_rs_scheduler #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_imm,
  input  logic [TAG_W-1:0]           in_dest,
  input  logic [31:0]                in_v1,
  input  logic [31:0]                in_v2,
  input  logic [TAG_W-1:0]           in_q1,
  input  logic [TAG_W-1:0]           in_q2,
  input  logic                       in_b1,
  input  logic                       in_b2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_data,
  output logic [OP_W-1:0]            alu_op,
  output logic [31:0]                alu_pc,
  output logic [31:0]                alu_imm,
  output logic [31:0]                alu_v1,
  output logic [31:0]                alu_v2,
  output logic [TAG_W-1:0]           alu_dest,
  output logic                       alu_empty,
  output logic [$clog2(ENTRIES):0]   count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic             b1;
    logic             b2;
  } entry_t;

  entry_t [ENTRIES-1:0] ent;
  logic   [ENTRIES-1:0] vld;
  logic   [ENTRIES-1:0] rdy;
  entry_t               new_ent;
  logic   [IDX_W-1:0]   free_idx;
  logic   [IDX_W-1:0]   sel_idx;
  logic                 sel_vld;
  logic                 enq;

  // Full station is the only case with no free slot, so the registered count alone gates dispatch.
  assign in_ready = (count != CNT_W'(ENTRIES));
  assign enq      = in_valid && in_ready && !flush;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      rdy[i] = vld[i] && !ent[i].b1 && !ent[i].b2;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Incoming op snoops the CDB in its enqueue cycle so a same-cycle broadcast is not missed.
  always_comb begin
    new_ent.op   = in_op;
    new_ent.pc   = in_pc;
    new_ent.imm  = in_imm;
    new_ent.dest = in_dest;
    new_ent.v1   = in_v1;
    new_ent.v2   = in_v2;
    new_ent.q1   = in_q1;
    new_ent.q2   = in_q2;
    new_ent.b1   = in_b1;
    new_ent.b2   = in_b2;
    if (cdb_valid && in_b1 && (in_q1 == cdb_tag)) begin
      new_ent.v1 = cdb_data;
      new_ent.b1 = 1'b0;
    end
    if (cdb_valid && in_b2 && (in_q2 == cdb_tag)) begin
      new_ent.v2 = cdb_data;
      new_ent.b2 = 1'b0;
    end
  end

`ifdef ALU_RS_AGE_EN
  // age[i][j] set means entry i was enqueued before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] age;
  logic [ENTRIES-1:0]              is_oldest;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      is_oldest[i] = rdy[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && rdy[j] && !age[i][j]) is_oldest[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (is_oldest[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (flush) begin
      age <= '0;
    end else if (enq) begin
      for (int j = 0; j < ENTRIES; j++) begin
        age[j][free_idx] <= 1'b1;
      end
      age[free_idx] <= '0;
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      ent <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (vld[i] && cdb_valid) begin
          if (ent[i].b1 && (ent[i].q1 == cdb_tag)) begin
            ent[i].v1 <= cdb_data;
            ent[i].b1 <= 1'b0;
          end
          if (ent[i].b2 && (ent[i].q2 == cdb_tag)) begin
            ent[i].v2 <= cdb_data;
            ent[i].b2 <= 1'b0;
          end
        end
      end
      // Enqueue targets a free slot and select a valid one, so they never collide.
      if (sel_vld) vld[sel_idx] <= 1'b0;
      if (enq) begin
        vld[free_idx] <= 1'b1;
        ent[free_idx] <= new_ent;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op    <= '0;
      alu_pc    <= '0;
      alu_imm   <= '0;
      alu_v1    <= '0;
      alu_v2    <= '0;
      alu_dest  <= '0;
      alu_empty <= 1'b1;
      count     <= '0;
    end else if (flush) begin
      alu_empty <= 1'b1;
      count     <= '0;
    end else begin
      alu_empty <= !sel_vld;
      if (sel_vld) begin
        alu_op   <= ent[sel_idx].op;
        alu_pc   <= ent[sel_idx].pc;
        alu_imm  <= ent[sel_idx].imm;
        alu_v1   <= ent[sel_idx].v1;
        alu_v2   <= ent[sel_idx].v2;
        alu_dest <= ent[sel_idx].dest;
      end
      case ({enq, sel_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler; expectations adapt to ALU_RS_AGE_EN where select policy differs.
module tb_alu_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [3:0]  in_dest;
  logic [31:0] in_v1;
  logic [31:0] in_v2;
  logic [3:0]  in_q1;
  logic [3:0]  in_q2;
  logic        in_b1;
  logic        in_b2;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [5:0]  alu_op;
  logic [31:0] alu_pc;
  logic [31:0] alu_imm;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [3:0]  alu_dest;
  logic        alu_empty;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  alu_rs_scheduler #(.ENTRIES(8), .TAG_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_dest(in_dest),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
    .in_b1(in_b1), .in_b2(in_b2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_op(alu_op), .alu_pc(alu_pc), .alu_imm(alu_imm),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_dest(alu_dest),
    .alu_empty(alu_empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drive_enq(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [3:0] dest, input logic b1, input logic [3:0] q1,
                           input logic b2, input logic [3:0] q2);
    in_valid = 1'b1;
    in_op    = op;
    in_pc    = 32'h1000 + {28'd0, dest};
    in_imm   = 32'h0;
    in_dest  = dest;
    in_v1    = v1;
    in_v2    = v2;
    in_b1    = b1;
    in_q1    = q1;
    in_b2    = b2;
    in_q2    = q2;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    drive_enq(6'd0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    in_valid = 1'b0;
    cdb_tag  = 4'd0;
    cdb_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_empty", 32'(alu_empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_alu_v1", alu_v1, 32'd0);
    chk("reset_alu_dest", 32'(alu_dest), 32'd0);

    // ADD with both operands available: presented two edges after dispatch.
    drive_enq(6'd1, 32'd5, 32'd7, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    chk("add_queued_count", 32'(count), 32'd1);
    chk("add_not_yet_issued", 32'(alu_empty), 32'd1);
    tick();
    chk("add_issued", 32'(alu_empty), 32'd0);
    chk("add_v1", alu_v1, 32'd5);
    chk("add_v2", alu_v2, 32'd7);
    chk("add_dest", 32'(alu_dest), 32'd3);
    chk("add_op", 32'(alu_op), 32'd1);
    chk("add_count_back", 32'(count), 32'd0);
    tick();
    chk("add_one_cycle", 32'(alu_empty), 32'd1);
    chk("add_hold_v1", alu_v1, 32'd5);

    // SUB waiting on tag 9; a different tag must not wake it.
    drive_enq(6'd2, 32'd0, 32'd3, 4'd5, 1'b1, 4'd9, 1'b0, 4'd0);
    tick();
    idle();
    cdb(4'd8, 32'hDEAD);
    tick();
    idle();
    tick();
    chk("sub_blocked_empty", 32'(alu_empty), 32'd1);
    chk("sub_blocked_count", 32'(count), 32'd1);
    cdb(4'd9, 32'h10);
    tick();
    idle();
    chk("sub_wake_not_same_edge", 32'(alu_empty), 32'd1);
    tick();
    chk("sub_issued", 32'(alu_empty), 32'd0);
    chk("sub_v1", alu_v1, 32'h10);
    chk("sub_v2", alu_v2, 32'd3);
    chk("sub_dest", 32'(alu_dest), 32'd5);
    tick();

    // Enqueue bypass: CDB broadcasts the pending tag in the dispatch cycle.
    drive_enq(6'd3, 32'd1, 32'd0, 4'd6, 1'b0, 4'd0, 1'b1, 4'd4);
    cdb(4'd4, 32'hAB);
    tick();
    idle();
    tick();
    chk("bypass_issued", 32'(alu_empty), 32'd0);
    chk("bypass_v2", alu_v2, 32'hAB);
    chk("bypass_dest", 32'(alu_dest), 32'd6);
    tick();

    // Fill the station with blocked ops; the ninth dispatch must be refused.
    for (int i = 0; i < 8; i++) begin
      drive_enq(6'd4, 32'd0, 32'd0, 4'(i), 1'b1, 4'(i), 1'b0, 4'd0);
      tick();
    end
    idle();
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive_enq(6'd5, 32'd1, 32'd2, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    chk("ninth_refused_count", 32'(count), 32'd8);
    tick();
    chk("ninth_not_issued", 32'(alu_empty), 32'd1);
    cdb(4'd5, 32'h55);
    tick();
    idle();
    chk("full_still_not_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_wake_issued", 32'(alu_empty), 32'd0);
    chk("full_wake_dest", 32'(alu_dest), 32'd5);
    chk("full_wake_v1", alu_v1, 32'h55);
    chk("full_after_count", 32'(count), 32'd7);
    chk("full_after_in_ready", 32'(in_ready), 32'd1);
    flush = 1'b1;
    tick();
    idle();
    chk("drain_flush_count", 32'(count), 32'd0);

    // A blocked in entry 0, B ready in entry 1, A woken as B enters.
    drive_enq(6'd6, 32'd0, 32'd0, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    tick();
    drive_enq(6'd7, 32'd0, 32'd0, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb(4'd2, 32'h22);
    tick();
    idle();
    chk("order1_none_yet", 32'(alu_empty), 32'd1);
    tick();
    chk("order1_first", 32'(alu_dest), 32'd1);
    tick();
    chk("order1_second", 32'(alu_dest), 32'd2);
    chk("order1_second_vld", 32'(alu_empty), 32'd0);
    tick();

    // Same race with A in entry 1 and B in entry 0.
    drive_enq(6'd8, 32'd0, 32'd0, 4'd7, 1'b1, 4'd12, 1'b0, 4'd0);
    tick();
    drive_enq(6'd6, 32'd0, 32'd0, 4'd1, 1'b1, 4'd13, 1'b0, 4'd0);
    cdb(4'd12, 32'hC);
    tick();
    idle();
    tick();
    chk("order2_filler", 32'(alu_dest), 32'd7);
    drive_enq(6'd7, 32'd0, 32'd0, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb(4'd13, 32'hD);
    tick();
    idle();
    tick();
`ifdef ALU_RS_AGE_EN
    chk("order2_first", 32'(alu_dest), 32'd1);
    tick();
    chk("order2_second", 32'(alu_dest), 32'd2);
`else
    chk("order2_first", 32'(alu_dest), 32'd2);
    tick();
    chk("order2_second", 32'(alu_dest), 32'd1);
`endif
    tick();
    chk("order2_count", 32'(count), 32'd0);

    // Flush with five queued ops and a concurrent dispatch and CDB hit.
    for (int i = 0; i < 5; i++) begin
      drive_enq(6'd9, 32'd0, 32'd0, 4'(i), 1'b1, 4'd14, 1'b0, 4'd0);
      tick();
    end
    idle();
    chk("preflush_count", 32'(count), 32'd5);
    flush = 1'b1;
    drive_enq(6'd10, 32'd1, 32'd1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    cdb(4'd14, 32'hE);
    tick();
    idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(alu_empty), 32'd1);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cdb(4'd14, 32'hE);
    tick();
    idle();
    tick();
    chk("postflush_empty", 32'(alu_empty), 32'd1);
    chk("postflush_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation-station scheduler for the integer ALU. It buffers up to `ENTRIES` decoded ALU/branch operations. It captures missing source operands from the common data bus (CDB) and selects one ready entry per cycle to drive the combinational ALU. It sits between the dispatch stage and the ALU, which reports results to the ROB.

## Interface
- `ENTRIES`, 8: station depth, power of two, 2..16.
- `TAG_W`, 4: ROB tag width.
- `OP_W`, 6: opcode width, same encoding the ALU decodes.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  misprediction flush from the ROB.
- `in_valid`  in  1  dispatch offers an operation.
- `in_ready`  out  1  station can accept an operation this cycle.
- `in_op`  in  OP_W  opcode.
- `in_pc`  in  32  instruction PC.
- `in_imm`  in  32  raw immediate.
- `in_dest`  in  TAG_W  ROB tag of the result.
- `in_v1`, `in_v2`  in  32  operand values (used when not busy).
- `in_q1`, `in_q2`  in  TAG_W  producer tags.
- `in_b1`, `in_b2`  in  1  operand still pending (wait on tag).
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  broadcast tag.
- `cdb_data`  in  32  broadcast value.
- `alu_op`, `alu_pc`, `alu_imm`, `alu_v1`, `alu_v2`  out  OP_W/32/32/32/32  registered operands to the ALU.
- `alu_dest`  out  TAG_W  ROB tag accompanying the ALU result.
- `alu_empty`  out  1  high when no operation is presented to the ALU this cycle.
- `count`  out  log2(ENTRIES)+1  occupied entries.

## Operation
- Each entry holds: valid, op, pc, imm, dest, v1/v2, q1/q2, b1/b2.
- **Enqueue.** When `in_valid && in_ready`, the lowest-index free entry is written.
  - If `cdb_valid` and `cdb_tag` matches a busy source in the same cycle, that source is written with `cdb_data` and its busy bit cleared (enqueue bypass).
- **Wakeup.** Every cycle, each valid entry compares `cdb_tag` against each busy source. On a match it latches `cdb_data` and clears the busy bit. Both sources may wake in the same cycle.
- **Ready.** An entry is ready when valid, `!b1`, and `!b2`. Wakeup or enqueue in cycle N makes an entry eligible in cycle N+1, never N.
- **Select.** At most one ready entry is chosen per cycle; the policy is set under Configuration.
  - The chosen entry's fields are registered onto the `alu_*` outputs and `alu_empty` is deasserted for exactly one cycle.
  - The entry is freed at that same edge.
- If no entry is ready, `alu_empty`=1. The `alu_*` data outputs hold their last values.
- `in_ready` = (`count` < `ENTRIES`), taken from the registered count. An entry freed by select this cycle is not reusable until the next cycle.
- `count` is incremented on enqueue, decremented on select, and unchanged when both happen.
- **Flush** (synchronous):
  - At the next edge all entries become invalid, `count`=0, and `alu_empty`=1.
  - Enqueue and select in the flush cycle are discarded.
  - CDB is ignored in that cycle.
- **Reset.** All entries are invalid, `count`=0, `alu_empty`=1, and every `alu_*` output is 0. `in_ready`=1 after reset.

## Timing
- Dispatch to ALU, minimum latency: an enqueued entry with no busy sources appears on the `alu_*` outputs one edge after the enqueue edge's following cycle, i.e. 2 edges after `in_valid` is sampled.
- CDB to ALU: a consumer is woken at edge E and presented at edge E+1.
- Throughput: 1 operation per cycle.
- `in_ready` is low only when the station is full. There is no combinational path from `in_valid` to `in_ready`.
- `rst` asserted mid-operation clears everything asynchronously. In-flight operations are lost; no partial writes survive.

## Configuration
- `ALU_RS_AGE_EN` defined:
  - Select picks the oldest ready entry by enqueue order, tracked with an `ENTRIES`×`ENTRIES` age matrix updated on enqueue.
  - Flush and reset clear the matrix.
- `ALU_RS_AGE_EN` undefined:
  - Select picks the lowest-index ready entry.
  - No age state is built.

## Test plan
- Reset, then enqueue ADD v1=5 v2=7 dest=3 with no busy sources → two edges later `alu_empty`=0, `alu_v1`=5, `alu_v2`=7, `alu_dest`=3 for one cycle; `count` returns to 0.
- Enqueue SUB with b1=1 q1=9 → stays queued. At edge E, CDB tag 9 data 0x10 → at edge E+1, `alu_v1`=0x10 is presented.
- Enqueue with b2=1 q2=4 while the CDB broadcasts tag 4 data 0xAB in the same cycle → the entry is dispatched the next cycle with `alu_v2`=0xAB.
- Fill 8 entries, all blocked → `in_ready`=0 and the 9th `in_valid` is ignored. Wake one entry → it dispatches, and `in_ready`=1 on the cycle after.
- Enqueue A (blocked) into entry 0 and B (ready) into entry 1, then wake A.
  - With `ALU_RS_AGE_EN`, once both are ready A issues before B.
  - Without it, A also issues first (index 0).
  - Repeat with A in entry 1 and B in entry 0: with `ALU_RS_AGE_EN`, A first; without it, B first.
- With 5 queued entries, assert `flush` for one cycle while `in_valid`=1 → next cycle `count`=0, `alu_empty`=1, and nothing is dispatched afterwards.
